// File: rtl/button_event_scheduler.sv
// Converts debounced button levels into a single stream of press / auto-repeat
// events, shared round-robin over one valid/ready output slot.
module button_event_scheduler #(
   parameter int NUM_BTN       = 4,
   parameter int ID_W          = 2,
   parameter int CNT_W         = 20,
   parameter int HOLD_CYCLES   = 500000,
   parameter int REPEAT_CYCLES = 100000,
   parameter bit REPEAT_EN     = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_level,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [ID_W-1:0]    evt_id,
   output logic               evt_repeat,
   output logic [NUM_BTN-1:0] pending,
   output logic               evt_lost,
   input  logic               clr_lost
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [NUM_BTN-1:0] pend_rep;
   logic [NUM_BTN-1:0] grant;
   logic [NUM_BTN-1:0] lost;

   logic               evt_valid_reg;
   logic [ID_W-1:0]    evt_id_reg;
   logic               evt_repeat_reg;
   logic               evt_lost_reg;
   logic [ID_W-1:0]    last_reg;

   logic               slot_free;
   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_rep;

   assign slot_free = ~evt_valid_reg | evt_ready;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         logic             prev_reg;
         logic             arm_reg;
         logic             phase_reg;
         logic             phase_next;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             pend_reg;
         logic             pend_next;
         logic             pend_rep_reg;
         logic             pend_rep_next;
         logic             rise;
         logic             req;
         logic             req_rep;
         logic             lost_hit;

         assign rise = arm_reg & btn_level[gi] & ~prev_reg;

         // Hold timer: first repeat after HOLD_CYCLES, then every REPEAT_CYCLES.
         always_comb begin
            cnt_next   = cnt_reg;
            phase_next = phase_reg;
            req        = 1'b0;
            req_rep    = 1'b0;
            if (!btn_level[gi]) begin
               cnt_next   = '0;
               phase_next = 1'b0;
            end else if (rise) begin
               cnt_next   = '0;
               phase_next = 1'b0;
               req        = 1'b1;
            end else if (arm_reg && REPEAT_EN) begin
               if (!phase_reg && cnt_reg == HOLD_LAST) begin
                  cnt_next   = '0;
                  phase_next = 1'b1;
                  req        = 1'b1;
                  req_rep    = 1'b1;
               end else if (phase_reg && cnt_reg == REPEAT_LAST) begin
                  cnt_next = '0;
                  req      = 1'b1;
                  req_rep  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end

         // A request that coincides with its own grant replaces the old entry.
         always_comb begin
            pend_next     = pend_reg;
            pend_rep_next = pend_rep_reg;
            lost_hit      = 1'b0;
            if (req) begin
               if (pend_reg && !grant[gi]) begin
                  lost_hit = 1'b1;
               end else begin
                  pend_next     = 1'b1;
                  pend_rep_next = req_rep;
               end
            end else if (grant[gi]) begin
               pend_next = 1'b0;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               prev_reg     <= 1'b1;
               arm_reg      <= 1'b0;
               cnt_reg      <= '0;
               phase_reg    <= 1'b0;
               pend_reg     <= 1'b0;
               pend_rep_reg <= 1'b0;
            end else begin
               prev_reg     <= btn_level[gi];
               if (!btn_level[gi]) begin
                  arm_reg <= 1'b1;
               end
               cnt_reg      <= cnt_next;
               phase_reg    <= phase_next;
               pend_reg     <= pend_next;
               pend_rep_reg <= pend_rep_next;
            end
         end

         assign pending[gi]  = pend_reg;
         assign pend_rep[gi] = pend_rep_reg;
         assign lost[gi]     = lost_hit;
         assign grant[gi]    = slot_free & grant_found & (grant_idx == ID_W'(gi));
      end
   endgenerate

   // Round-robin search starting just after the most recently granted index.
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_rep   = 1'b0;
      for (int k = 1; k <= NUM_BTN; k++) begin
         idx = int'(last_reg) + k;
         if (idx >= NUM_BTN) begin
            idx = idx - NUM_BTN;
         end
         if (!grant_found && pending[idx]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(idx);
            grant_rep   = pend_rep[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid_reg  <= 1'b0;
         evt_id_reg     <= '0;
         evt_repeat_reg <= 1'b0;
         evt_lost_reg   <= 1'b0;
         last_reg       <= ID_W'(NUM_BTN - 1);
      end else begin
         if (slot_free) begin
            if (grant_found) begin
               evt_valid_reg  <= 1'b1;
               evt_id_reg     <= grant_idx;
               evt_repeat_reg <= grant_rep;
               last_reg       <= grant_idx;
            end else begin
               evt_valid_reg <= 1'b0;
            end
         end
         if (|lost) begin
            evt_lost_reg <= 1'b1;
         end else if (clr_lost) begin
            evt_lost_reg <= 1'b0;
         end
      end
   end

   assign evt_valid  = evt_valid_reg;
   assign evt_id     = evt_id_reg;
   assign evt_repeat = evt_repeat_reg;
   assign evt_lost   = evt_lost_reg;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler: press latency, round-robin order,
// auto-repeat spacing, backpressure/loss, and reset behaviour.
module tb_button_event_scheduler;

   localparam int NUM_BTN = 4;
   localparam int ID_W    = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_BTN-1:0] btn_level = '0;
   logic               evt_ready = 1'b1;
   logic               clr_lost = 1'b0;
   logic               evt_valid;
   logic [ID_W-1:0]    evt_id;
   logic               evt_repeat;
   logic [NUM_BTN-1:0] pending;
   logic               evt_lost;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int ev_id[$];
   int ev_rep[$];
   int ev_cyc[$];

   button_event_scheduler #(
      .NUM_BTN(NUM_BTN), .ID_W(ID_W), .CNT_W(20),
      .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
      .evt_repeat(evt_repeat), .pending(pending), .evt_lost(evt_lost),
      .clr_lost(clr_lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Log every accepted transfer; it completes on the following rising edge.
   always @(negedge clk) begin
      if (rst_n && evt_valid && evt_ready) begin
         ev_id.push_back(int'(evt_id));
         ev_rep.push_back(int'(evt_repeat));
         ev_cyc.push_back(cyc);
         $display("event: id=%0d repeat=%0d cycle=%0d", evt_id, evt_repeat, cyc);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pop_evt(input string tag, input int exp_id, input int exp_rep, output int c);
      c = 0;
      if (ev_id.size() == 0) begin
         check_val({tag, "_present"}, ev_id.size(), 1);
      end else begin
         check_val({tag, "_id"}, ev_id.pop_front(), exp_id);
         check_val({tag, "_rep"}, ev_rep.pop_front(), exp_rep);
         c = ev_cyc.pop_front();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0, c1, c2, c3, c4;

      // Reset state
      #12;
      check_val("rst_valid", evt_valid, 0);
      check_val("rst_id", evt_id, 0);
      check_val("rst_repeat", evt_repeat, 0);
      check_val("rst_pending", pending, 0);
      check_val("rst_lost", evt_lost, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      // Single press of button 2, held 3 cycles
      btn_level = 4'b0100;
      tick(1);
      check_val("t1_pend", pending, 4'b0100);
      check_val("t1_valid_early", evt_valid, 0);
      tick(1);
      check_val("t1_valid", evt_valid, 1);
      check_val("t1_id", evt_id, 2);
      check_val("t1_repeat", evt_repeat, 0);
      check_val("t1_pend_clr", pending, 0);
      tick(1);
      check_val("t1_valid_drop", evt_valid, 0);
      btn_level = 4'b0000;
      tick(3);
      pop_evt("t1_ev", 2, 0, c0);
      check_val("t1_count", ev_id.size(), 0);

      // Round-robin from last=3 after reset
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick(2);
      btn_level = 4'b1011;
      tick(1);
      check_val("t2_pend", pending, 4'b1011);
      tick(1);
      check_val("t2_first", evt_id, 0);
      tick(1);
      check_val("t2_second", evt_id, 1);
      tick(1);
      check_val("t2_third", evt_id, 3);
      check_val("t2_valid3", evt_valid, 1);
      btn_level = 4'b0000;
      tick(1);
      check_val("t2_idle", evt_valid, 0);
      tick(1);
      btn_level = 4'b0011;
      tick(4);
      btn_level = 4'b0000;
      tick(2);
      pop_evt("t2_ev0", 0, 0, c0);
      pop_evt("t2_ev1", 1, 0, c1);
      pop_evt("t2_ev2", 3, 0, c2);
      check_val("t2_gap01", c1 - c0, 1);
      check_val("t2_gap12", c2 - c1, 1);
      pop_evt("t2_ev3", 0, 0, c3);
      pop_evt("t2_ev4", 1, 0, c4);
      check_val("t2_count", ev_id.size(), 0);

      // Auto-repeat: button 1 held 20 cycles
      btn_level = 4'b0010;
      tick(20);
      btn_level = 4'b0000;
      tick(6);
      pop_evt("t3_press", 1, 0, c0);
      pop_evt("t3_rep1", 1, 1, c1);
      pop_evt("t3_rep2", 1, 1, c2);
      pop_evt("t3_rep3", 1, 1, c3);
      check_val("t3_gap_hold", c1 - c0, 8);
      check_val("t3_gap_rep2", c2 - c1, 4);
      check_val("t3_gap_rep3", c3 - c2, 4);
      check_val("t3_count", ev_id.size(), 0);

      // Backpressure and loss on button 0
      evt_ready = 1'b0;
      btn_level = 4'b0001;
      tick(1);
      check_val("t4_pend1", pending, 4'b0001);
      tick(1);
      check_val("t4_valid", evt_valid, 1);
      check_val("t4_id", evt_id, 0);
      btn_level = 4'b0000;
      tick(1);
      btn_level = 4'b0001;
      tick(1);
      check_val("t4_pend2", pending, 4'b0001);
      check_val("t4_held_id", evt_id, 0);
      check_val("t4_held_valid", evt_valid, 1);
      check_val("t4_no_lost", evt_lost, 0);
      btn_level = 4'b0000;
      tick(1);
      btn_level = 4'b0001;
      tick(1);
      check_val("t4_lost", evt_lost, 1);
      check_val("t4_pend3", pending, 4'b0001);
      btn_level = 4'b0000;
      check_val("t4_nolog", ev_id.size(), 0);
      evt_ready = 1'b1;
      tick(1);
      check_val("t4_second_valid", evt_valid, 1);
      check_val("t4_pend_empty", pending, 0);
      tick(1);
      check_val("t4_idle", evt_valid, 0);
      pop_evt("t4_ev0", 0, 0, c0);
      pop_evt("t4_ev1", 0, 0, c1);
      check_val("t4_count", ev_id.size(), 0);
      check_val("t4_lost_sticky", evt_lost, 1);
      clr_lost = 1'b1;
      tick(1);
      clr_lost = 1'b0;
      check_val("t4_lost_clr", evt_lost, 0);

      // Button 3 held through reset
      btn_level = 4'b1000;
      #2;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check_val("t5_no_valid", evt_valid, 0);
      check_val("t5_no_pend", pending, 0);
      btn_level = 4'b0000;
      tick(1);
      btn_level = 4'b1000;
      tick(1);
      check_val("t5_pend", pending, 4'b1000);
      tick(1);
      check_val("t5_valid", evt_valid, 1);
      check_val("t5_id", evt_id, 3);
      btn_level = 4'b0000;
      tick(2);
      pop_evt("t5_ev", 3, 0, c0);
      check_val("t5_count", ev_id.size(), 0);

      // Asynchronous reset with an event presented and two pending
      evt_ready = 1'b0;
      btn_level = 4'b0001;
      tick(1);
      tick(1);
      btn_level = 4'b0110;
      tick(1);
      check_val("t6_valid_pre", evt_valid, 1);
      check_val("t6_pend_pre", pending, 4'b0110);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_valid", evt_valid, 0);
      check_val("t6_id", evt_id, 0);
      check_val("t6_pend", pending, 0);
      btn_level = 4'b0000;
      tick(2);
      rst_n = 1'b1;
      evt_ready = 1'b1;
      tick(4);
      check_val("t6_after_valid", evt_valid, 0);
      check_val("t6_count", ev_id.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
